age_reservestation: RTL

AGE_RESERVESTATION -- requirements
Module: age_reservestation

---
 rtl/rs_pkg.sv | 18 +
 rtl/rs_age_picker.sv | 18 +
 rtl/age_reservestation.sv | 126 ++++++++++++
 3 files changed

// File: rtl/rs_pkg.sv
// rs_pkg: shared defaults, field widths and one-hot helpers for the reservation station
package rs_pkg;
  localparam int RS_DEPTH = 16;
  localparam int RS_TAG_W = 4;
  localparam int RS_DATA_W = 32;
  localparam int RS_NCDB = 2;
  localparam int OPC_W = 7;
  localparam int PREC_W = 3;
  localparam int MAX_DEPTH = 64;
  function automatic logic [5:0] lowest_one(input logic [MAX_DEPTH-1:0] v);
    lowest_one = '0;
    for (int i = MAX_DEPTH - 1; i >= 0; i--) if (v[i]) lowest_one = 6'(i);
  endfunction
  function automatic logic [5:0] onehot_idx(input logic [MAX_DEPTH-1:0] v);
    onehot_idx = '0;
    for (int i = 0; i < MAX_DEPTH; i++) if (v[i]) onehot_idx |= 6'(i);
  endfunction
endpackage

// File: rtl/rs_age_picker.sv
// rs_age_picker: one-hot grant of the oldest ready entry from an age matrix (older[i][j] = i older than j)
module rs_age_picker #(
  parameter int DEPTH = 16
) (
  input  logic [DEPTH-1:0]            ready,
  input  logic [DEPTH-1:0][DEPTH-1:0] older,
  output logic [DEPTH-1:0]            grant,
  output logic                        valid
);
  for (genvar i = 0; i < DEPTH; i++) begin : g_col
    logic [DEPTH-1:0] col;
    for (genvar j = 0; j < DEPTH; j++) begin : g_row
      assign col[j] = older[j][i];
    end
    assign grant[i] = ready[i] & ~|(col & ready);
  end
  assign valid = |ready;
endmodule

// File: rtl/age_reservestation.sv
// age_reservestation: age-ordered reservation station with CDB wakeup and oldest-ready issue
module age_reservestation import rs_pkg::*; #(
  parameter int DEPTH  = RS_DEPTH,
  parameter int TAG_W  = RS_TAG_W,
  parameter int DATA_W = RS_DATA_W,
  parameter int NCDB   = RS_NCDB
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     rollback,
  input  logic                     in_config,
  input  logic [DATA_W-1:0]        in_value_1,
  input  logic [DATA_W-1:0]        in_value_2,
  input  logic [TAG_W-1:0]         in_Q1,
  input  logic [TAG_W-1:0]         in_Q2,
  input  logic                     in_Q1_need,
  input  logic                     in_Q2_need,
  input  logic [DATA_W-1:0]        in_value_pc,
  input  logic [OPC_W-1:0]         in_opcode,
  input  logic [PREC_W-1:0]        in_precise,
  input  logic                     in_more_precise,
  input  logic [DATA_W-1:0]        in_imm,
  input  logic [TAG_W-1:0]         in_rob_entry,
  input  logic [NCDB-1:0]          cdb_valid,
  input  logic [NCDB*DATA_W-1:0]   cdb_val,
  input  logic [NCDB*TAG_W-1:0]    cdb_tag,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     out_config,
  output logic [DATA_W-1:0]        out_value_1,
  output logic [DATA_W-1:0]        out_value_2,
  output logic [DATA_W-1:0]        out_value_pc,
  output logic [OPC_W-1:0]         out_opcode,
  output logic [PREC_W-1:0]        out_precise,
  output logic                     out_more_precise,
  output logic [DATA_W-1:0]        out_imm,
  output logic [TAG_W-1:0]         out_rob_entry
);
  localparam int IW = $clog2(DEPTH);
  logic [DEPTH-1:0] occ, q1n, q2n, ready, grant, w1, w2;
  logic [DEPTH-1:0][DEPTH-1:0] older;
  logic [DATA_W-1:0] v1 [DEPTH], v2 [DEPTH], pc [DEPTH], imm [DEPTH], wv1 [DEPTH], wv2 [DEPTH];
  logic [TAG_W-1:0] q1 [DEPTH], q2 [DEPTH], rob [DEPTH];
  logic [OPC_W-1:0] opc [DEPTH];
  logic [PREC_W-1:0] prec [DEPTH];
  logic [DEPTH-1:0] mp;
  logic any, acc, i1, i2;
  logic [DATA_W-1:0] iv1, iv2;
  logic [IW-1:0] slot, gidx;
  function automatic logic [DATA_W:0] snoop(input logic [TAG_W-1:0] t);
    snoop = '0;
    for (int k = NCDB - 1; k >= 0; k--)
      if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == t) snoop = {1'b1, cdb_val[k*DATA_W +: DATA_W]};
  endfunction
  assign full  = count == (IW+1)'(DEPTH);
  assign ready = occ & ~q1n & ~q2n;
  assign acc   = rdy & in_config & ~full & ~rollback;
  assign slot  = IW'(lowest_one(MAX_DEPTH'(~occ)));
  assign gidx  = IW'(onehot_idx(MAX_DEPTH'(grant)));
  rs_age_picker #(.DEPTH(DEPTH)) u_pick (.ready(ready), .older(older), .grant(grant), .valid(any));
  // broadcast matches for stored operands and for the operands being dispatched
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      {w1[i], wv1[i]} = snoop(q1[i]);
      {w2[i], wv2[i]} = snoop(q2[i]);
    end
    {i1, iv1} = snoop(in_Q1);
    {i2, iv2} = snoop(in_Q2);
  end
  // occupancy, age matrix, wakeup capture, insert and issue register
  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= '0;
      older <= '0;
      count <= '0;
      out_config <= 1'b0;
    end else if (rdy) begin
      if (rollback) begin
        occ <= '0;
        count <= '0;
        out_config <= 1'b0;
      end else begin
        out_config <= any;
        if (any) begin
          out_value_1 <= v1[gidx];
          out_value_2 <= v2[gidx];
          out_value_pc <= pc[gidx];
          out_opcode <= opc[gidx];
          out_precise <= prec[gidx];
          out_more_precise <= mp[gidx];
          out_imm <= imm[gidx];
          out_rob_entry <= rob[gidx];
        end
        count <= count + (IW+1)'(acc) - (IW+1)'(any);
        occ <= (occ & ~grant) | (acc ? DEPTH'(1) << slot : '0);
        for (int i = 0; i < DEPTH; i++) begin
          if (occ[i] && q1n[i] && w1[i]) begin
            v1[i] <= wv1[i];
            q1n[i] <= 1'b0;
          end
          if (occ[i] && q2n[i] && w2[i]) begin
            v2[i] <= wv2[i];
            q2n[i] <= 1'b0;
          end
        end
        if (acc) begin
          v1[slot] <= in_Q1_need && i1 ? iv1 : in_value_1;
          v2[slot] <= in_Q2_need && i2 ? iv2 : in_value_2;
          q1n[slot] <= in_Q1_need & ~i1;
          q2n[slot] <= in_Q2_need & ~i2;
          q1[slot] <= in_Q1;
          q2[slot] <= in_Q2;
          pc[slot] <= in_value_pc;
          imm[slot] <= in_imm;
          rob[slot] <= in_rob_entry;
          opc[slot] <= in_opcode;
          prec[slot] <= in_precise;
          mp[slot] <= in_more_precise;
          older[slot] <= '0;
          for (int j = 0; j < DEPTH; j++) older[j][slot] <= IW'(j) != slot;
        end
      end
    end
  end
endmodule
